// File: rtl/mqam_pkg.sv
// Shared definitions for the M-QAM symbol back-end:
// mode encodings, per-axis bit counts and the serializer state type.
package mqam_pkg;

  localparam logic [1:0] MODE_QPSK = 2'd0;
  localparam logic [1:0] MODE_16   = 2'd1;
  localparam logic [1:0] MODE_64   = 2'd2;

  typedef enum logic [0:0] {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

  // Reserved mode 3 decodes as 16QAM.
  function automatic logic [1:0] bits_per_axis(input logic [1:0] mode);
    case (mode)
      MODE_QPSK: return 2'd1;
      MODE_64:   return 2'd3;
      default:   return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/mqam_slicer.sv
// Per-axis decision slicer: integrated sum -> right-justified decision bits
// {s} (QPSK), {s, inner} (16QAM) or {s, inner, mid} (64QAM).
module mqam_slicer
  import mqam_pkg::*;
#(
  parameter int unsigned ACCW = 25
) (
  input  logic signed [ACCW-1:0] x,
  input  logic        [ACCW-1:0] t,
  input  logic        [1:0]      mode,
  output logic        [2:0]      bits
);

  logic [ACCW:0] xe, a, te, t2, t4, t6;
  logic          s, lt2, lt4, mid;

  // One extra bit so |most-negative| and 6T compare without wrapping.
  always_comb begin
    xe   = {x[ACCW-1], x};
    s    = ~x[ACCW-1];
    a    = x[ACCW-1] ? ('0 - xe) : xe;
    te   = {1'b0, t};
    t2   = te << 1;
    t4   = te << 2;
    t6   = t4 + t2;
    lt2  = a < t2;
    lt4  = a < t4;
    mid  = (a >= t2) && (a < t6);
    bits = '0;
    case (bits_per_axis(mode))
      2'd1:    bits = {2'b00, s};
      2'd3:    bits = {s, lt4, mid};
      default: bits = {1'b0, s, lt2};
    endcase
  end

endmodule

// File: rtl/mqam_demod_backend.sv
// Integrate-and-dump of matched-filter I/Q, run-time QPSK/16/64QAM slicing,
// 2-entry symbol queue and valid/ready serial bit output.
module mqam_demod_backend
  import mqam_pkg::*;
#(
  parameter int DW  = 20,
  parameter int SPS = 16,
  parameter int LVL = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           mode,
  input  logic                 sym_sync,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] fir_i,
  input  logic signed [DW-1:0] fir_q,
  output logic                 bit_out,
  output logic                 bit_valid,
  input  logic                 bit_ready,
  output logic [5:0]           sym_word,
  output logic                 sym_strobe,
  output logic                 overflow
);

  localparam int ACCW = DW + $clog2(SPS) + 1;
  localparam int CW   = $clog2(SPS);
  localparam logic [ACCW-1:0] T = ACCW'(LVL * SPS);

  logic signed [ACCW-1:0] acc_i, acc_q, sum_i, sum_q;
  logic [CW-1:0]          cnt;
  logic [1:0]             mode_lat;
  logic                   dump;
  logic [2:0]             bi, bq, sym_nbits;

  assign sum_i = acc_i + ACCW'(fir_i);
  assign sum_q = acc_q + ACCW'(fir_q);
  assign dump  = in_valid && !sym_sync && (cnt == CW'(SPS - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_i    <= '0;
      acc_q    <= '0;
      cnt      <= '0;
      mode_lat <= MODE_16;
    end else if (sym_sync) begin
      acc_i <= in_valid ? ACCW'(fir_i) : '0;
      acc_q <= in_valid ? ACCW'(fir_q) : '0;
      cnt   <= in_valid ? CW'(1) : '0;
      if (in_valid) mode_lat <= mode;
    end else if (in_valid) begin
      if (cnt == '0) mode_lat <= mode;
      if (dump) begin
        acc_i <= '0;
        acc_q <= '0;
        cnt   <= '0;
      end else begin
        acc_i <= sum_i;
        acc_q <= sum_q;
        cnt   <= cnt + CW'(1);
      end
    end
  end

  mqam_slicer #(.ACCW(ACCW)) u_slice_i (.x(sum_i), .t(T), .mode(mode_lat), .bits(bi));
  mqam_slicer #(.ACCW(ACCW)) u_slice_q (.x(sum_q), .t(T), .mode(mode_lat), .bits(bq));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sym_word   <= '0;
      sym_nbits  <= '0;
      sym_strobe <= 1'b0;
    end else begin
      sym_strobe <= dump;
      if (dump) begin
        sym_word  <= {bi[2], bq[2], bi[1], bq[1], bi[0], bq[0]};
        sym_nbits <= {bits_per_axis(mode_lat), 1'b0};
      end
    end
  end

  logic [5:0] q_word [2];
  logic [2:0] q_nb   [2];
  logic       wptr, rptr, full, empty, push, pop, accept, last;
  logic [1:0] q_cnt;
  ser_state_t state;
  logic [5:0] shreg;
  logic [2:0] left;

  assign push   = sym_strobe;
  assign full   = (q_cnt == 2'd2);
  assign empty  = (q_cnt == 2'd0);
  assign accept = push && (!full || pop);
  assign last   = (state == SER_SHIFT) && bit_ready && (left == 3'd1);
  assign pop    = !empty && ((state == SER_IDLE) || last);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr     <= 1'b0;
      rptr     <= 1'b0;
      q_cnt    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        q_word[wptr] <= sym_word;
        q_nb[wptr]   <= sym_nbits;
        wptr         <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      case ({accept, pop})
        2'b10:   q_cnt <= q_cnt + 2'd1;
        2'b01:   q_cnt <= q_cnt - 2'd1;
        default: ;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  // Words load MSB-aligned so bit 5 is always the next bit on the wire.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= SER_IDLE;
      shreg <= '0;
      left  <= '0;
    end else if (pop) begin
      state <= SER_SHIFT;
      shreg <= q_word[rptr] << (3'd6 - q_nb[rptr]);
      left  <= q_nb[rptr];
    end else if ((state == SER_SHIFT) && bit_ready) begin
      if (left == 3'd1) state <= SER_IDLE;
      shreg <= shreg << 1;
      left  <= left - 3'd1;
    end
  end

  assign bit_valid = (state == SER_SHIFT);
  assign bit_out   = bit_valid & shreg[5];

endmodule
